aclock_disp_scan: RTL



---
 rtl/aclock_disp_scan.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aclock_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the alarm clock: per-frame snapshot,
// leading-zero blanking, dot separators. Alarm blink is built only with ACLOCK_DISP_BLINK_EN.
//
// state   | meaning
// DIG_S0  | seconds units lit (an[0]); frame starts here, snapshot taken on entry
// DIG_S1  | seconds tens lit (an[1])
// DIG_M0  | minutes units lit (an[2]), dot on
// DIG_M1  | minutes tens lit (an[3])
// DIG_H0  | hours units lit (an[4]), dot on
// DIG_H1  | hours tens lit (an[5]), dark when zero
module aclock_disp_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] h1,
  input  logic [3:0] h0,
  input  logic [3:0] m1,
  input  logic [3:0] m0,
  input  logic [3:0] s1,
  input  logic [3:0] s0,
  input  logic       alarm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       alarm_led
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    DIG_S0 = 3'd0,
    DIG_S1 = 3'd1,
    DIG_M0 = 3'd2,
    DIG_M1 = 3'd3,
    DIG_H0 = 3'd4,
    DIG_H1 = 3'd5
  } digit_e;

  digit_e           idx_q, idx_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [5:0][3:0]  live;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             alarm_q;
  logic [3:0]       digit;
  logic             tick, wrap, blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign live = {{2'b00, h1}, h0, m1, m0, s1, s0};
  assign tick = (pcnt_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == DIG_H1);

`ifdef ACLOCK_DISP_BLINK_EN
  localparam int FW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic          phase_q, phase_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    if (!alarm) begin
      phase_d = 1'b0;
      fcnt_d  = '0;
    end else if (wrap) begin
      if (fcnt_q == FW'(BLINK_DIV - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Blanking follows the phase the new digit will be shown in.
  assign blank = alarm & phase_d;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_DIV > 0);
  assign blank = 1'b0;
`endif

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    digit  = '0;
    if (tick) begin
      idx_d = (idx_q == DIG_H1) ? DIG_S0 : digit_e'(idx_q + 3'd1);
      // On the frame wrap the fresh inputs feed the first digit directly.
      if (wrap) snap_d = live;
      digit = snap_d[idx_d];
      seg_d = seg_decode(digit);
      dp_d  = !((idx_d == DIG_M0) || (idx_d == DIG_H0));
      an_d  = ~(6'b000001 << idx_d);
      if ((idx_d == DIG_H1) && (digit == 4'd0)) an_d = 6'b111111;
      if (blank) an_d = 6'b111111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q  <= '0;
      idx_q   <= DIG_S0;
      snap_q  <= '0;
      an_q    <= 6'b111111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      alarm_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      alarm_q <= alarm;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign alarm_led = alarm_q;

endmodule
